dcache_dm: RTL and testbench

- Parametrised direct-mapped, write-through, no-write-allocate data cache.
- Sits between the core's load/store path (ALU address, rs2 write data, ResultSrc read-back) and a variable-latency backing data memory.
- Hits are served combinationally in the same cycle; misses and all writes stall the core through a handshake FSM.
- Successor to the fixed single-cycle data memory path: adds configurable geometry, a multi-cycle memory interface, flush, and hit/miss counters.

---
 rtl/dcache_pkg.sv | 14 +
 rtl/dcache_array.sv | 47 ++++
 rtl/dcache_dm.sv | 128 ++++++++++++
 tb/tb_dcache_dm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and address-geometry helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    function automatic int log2i(input int n);
        return $clog2(n);
    endfunction

    function automatic int tag_bits(input int aw, input int sets, input int wpl);
        return aw - 2 - $clog2(sets) - $clog2(wpl);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/data storage with combinational read, synchronous write and a whole-cache valid clear.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W = 24,
    parameter int DATA_WIDTH = 32,
    localparam int IW = log2i(SETS),
    localparam int OW = log2i(WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IW-1:0]         rd_index,
    input  logic [OW-1:0]         rd_word,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_index,
    input  logic [OW-1:0]         wr_word,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  tag_en,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  clear
);

    logic [DATA_WIDTH-1:0] data [SETS*WORDS_PER_LINE];
    logic [TAG_W-1:0]      tags [SETS];
    logic [SETS-1:0]       valid;

    assign rd_data  = data[{rd_index, rd_word}];
    assign rd_tag   = tags[rd_index];
    assign rd_valid = valid[rd_index];

    always_ff @(posedge clk) begin
        if (wr_en) data[{wr_index, wr_word}] <= wr_data;
        if (tag_en) tags[wr_index] <= wr_tag;
    end

    // A clear coinciding with a line fill wins, so the fresh line is dropped too.
    always_ff @(posedge clk or posedge rst)
        if (rst) valid <= '0;
        else if (clear) valid <= '0;
        else if (tag_en) valid[wr_index] <= 1'b1;

endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-through, no-write-allocate data cache with a
// stalling handshake to a variable-latency backing memory.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_valid,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    input  logic                     flush,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ready,
    output logic [CNT_WIDTH-1:0]     hit_count,
    output logic [CNT_WIDTH-1:0]     miss_count
);

    localparam int OW = log2i(WORDS_PER_LINE);
    localparam int IW = log2i(SETS);
    localparam int TW = tag_bits(ADDRESS_WIDTH, SETS, WORDS_PER_LINE);

    state_t state, next;
    logic [ADDRESS_WIDTH-3:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic [OW-1:0]            cnt;
    logic [TW-1:0]            rd_tag;
    logic                     rd_valid, hit, flush_pending, replay, apply, fill, count_en;
    logic                     unused_bits;

    wire [OW-1:0] cpu_word  = cpu_addr[2 +: OW];
    wire [IW-1:0] cpu_index = cpu_addr[2+OW +: IW];
    wire [TW-1:0] cpu_tag   = cpu_addr[ADDRESS_WIDTH-1 -: TW];
    wire [IW-1:0] lat_index = lat_addr[OW +: IW];
    wire [TW-1:0] lat_tag   = lat_addr[ADDRESS_WIDTH-3 -: TW];

    assign unused_bits = ^cpu_addr[1:0];
    assign hit         = rd_valid && rd_tag == cpu_tag;
    assign fill        = state == REFILL && mem_ready;
    assign mem_wdata   = lat_wdata;
    // The first IDLE cycle after a refill replays the held load; it was already counted.
    assign count_en    = state == IDLE && cpu_valid && !replay;
    assign apply       = (flush || flush_pending) && (state == IDLE || next == IDLE);

    dcache_array #(
        .SETS(SETS), .WORDS_PER_LINE(WORDS_PER_LINE), .TAG_W(TW), .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk(clk),
        .rst(rst),
        .rd_index(cpu_index),
        .rd_word(cpu_word),
        .rd_tag(rd_tag),
        .rd_valid(rd_valid),
        .rd_data(cpu_rdata),
        .wr_en(fill || (state == IDLE && cpu_valid && cpu_we && hit)),
        .wr_index(state == REFILL ? lat_index : cpu_index),
        .wr_word(state == REFILL ? cnt : cpu_word),
        .wr_data(state == REFILL ? mem_rdata : cpu_wdata),
        .tag_en(fill && cnt == OW'(WORDS_PER_LINE - 1)),
        .wr_tag(lat_tag),
        .clear(apply)
    );

    always_comb begin
        next = state;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        cpu_stall = 1'b0;
        case (state)
            IDLE: if (cpu_valid && (cpu_we || !hit)) begin
                cpu_stall = 1'b1;
                next = cpu_we ? WRITE : REFILL;
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_req = 1'b1;
                mem_addr = {lat_addr[ADDRESS_WIDTH-3:OW], cnt, 2'b00};
                if (mem_ready && cnt == OW'(WORDS_PER_LINE - 1)) next = IDLE;
            end
            WRITE: begin
                cpu_stall = 1'b1;
                mem_req = 1'b1;
                mem_we = 1'b1;
                mem_addr = {lat_addr, 2'b00};
                if (mem_ready) next = DONE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            flush_pending <= 1'b0;
            replay <= 1'b0;
            lat_addr <= '0;
            lat_wdata <= '0;
            hit_count <= '0;
            miss_count <= '0;
        end else begin
            state <= next;
            flush_pending <= (flush || flush_pending) && !apply;
            replay <= state == REFILL && next == IDLE;
            if (state == IDLE && cpu_valid) begin
                lat_addr <= cpu_addr[ADDRESS_WIDTH-1:2];
                lat_wdata <= cpu_wdata;
                cnt <= '0;
            end
            if (fill) cnt <= cnt + 1'b1;
            if (count_en && hit && hit_count != '1) hit_count <= hit_count + 1'b1;
            if (count_en && !hit && miss_count != '1) miss_count <= miss_count + 1'b1;
        end

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed self-checking bench for dcache_dm against a variable-latency memory model.
module tb_dcache_dm;

    logic        clk = 0, rst = 1;
    logic        cpu_valid = 0, cpu_we = 0, flush = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
    logic        cpu_stall, mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] hit_count, miss_count;

    logic [31:0] mem_arr [256];
    int          lat = 0, wait_cnt = 0, xfers = 0, unstable = 0;
    logic        hold = 0, hold_we = 0;
    logic [31:0] hold_addr = 0, hold_wdata = 0;
    int          checks = 0, errors = 0;

    dcache_dm dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    assign mem_ready = mem_req && wait_cnt >= lat;
    assign mem_rdata = mem_arr[mem_addr[9:2]];

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h1000_0000 + i;
        mem_arr[16] <= 32'h11;
        mem_arr[17] <= 32'h22;
        mem_arr[18] <= 32'h33;
        mem_arr[19] <= 32'h44;
    end

    always @(posedge clk or posedge rst)
        if (rst) begin
            wait_cnt <= 0;
            hold <= 0;
        end else begin
            if (hold && (!mem_req || mem_addr != hold_addr || mem_we != hold_we || mem_wdata != hold_wdata))
                unstable <= unstable + 1;
            hold <= mem_req && !mem_ready;
            hold_addr <= mem_addr;
            hold_we <= mem_we;
            hold_wdata <= mem_wdata;
            if (mem_req && mem_ready) begin
                xfers <= xfers + 1;
                wait_cnt <= 0;
                if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
            end else if (mem_req) wait_cnt <= wait_cnt + 1;
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int flush_at, output int stalls, output logic [31:0] rdata);
        @(negedge clk);
        cpu_valid = 1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wdata;
        stalls = 0;
        #1;
        while (cpu_stall && stalls < 200) begin
            @(negedge clk);
            flush = (stalls == flush_at);
            #1;
            stalls++;
        end
        rdata = cpu_rdata;
        @(negedge clk);
        cpu_valid = 0;
        flush = 0;
    endtask

    int          st, x0;
    logic [31:0] rd;

    initial begin
        #12;
        check("rst_stall", {31'b0, cpu_stall}, 0);
        check("rst_mem_req", {31'b0, mem_req}, 0);
        check("rst_hits", {16'b0, hit_count}, 0);
        check("rst_misses", {16'b0, miss_count}, 0);
        @(negedge clk);
        rst = 0;

        x0 = xfers;
        access(0, 32'h40, 0, -1, st, rd);
        check("cold_stall", st, 5);
        check("cold_rdata", rd, 32'h11);
        check("cold_xfers", xfers - x0, 4);
        check("cold_miss", {16'b0, miss_count}, 1);
        access(0, 32'h48, 0, -1, st, rd);
        check("hit_stall", st, 0);
        check("hit_rdata", rd, 32'h33);
        check("hit_count", {16'b0, hit_count}, 1);

        lat = 3;
        x0 = xfers;
        access(0, 32'h100, 0, -1, st, rd);
        check("slow_stall", st, 17);
        check("slow_xfers", xfers - x0, 4);
        check("slow_stable", unstable, 0);
        check("slow_rdata", rd, 32'h1000_0040);
        check("slow_miss", {16'b0, miss_count}, 2);
        lat = 0;

        x0 = xfers;
        access(1, 32'h44, 32'hDEAD_BEEF, -1, st, rd);
        check("wh_stall", st, 2);
        check("wh_xfers", xfers - x0, 1);
        check("wh_mem", mem_arr[17], 32'hDEAD_BEEF);
        check("wh_hits", {16'b0, hit_count}, 2);
        access(0, 32'h44, 0, -1, st, rd);
        check("wh_load_stall", st, 0);
        check("wh_load_rdata", rd, 32'hDEAD_BEEF);
        check("wh_load_hits", {16'b0, hit_count}, 3);

        access(1, 32'h200, 32'hCAFE, -1, st, rd);
        check("wm_stall", st, 2);
        check("wm_mem", mem_arr[128], 32'hCAFE);
        check("wm_miss", {16'b0, miss_count}, 3);
        access(0, 32'h200, 0, -1, st, rd);
        check("wm_load_stall", st, 5);
        check("wm_load_rdata", rd, 32'hCAFE);
        check("wm_load_miss", {16'b0, miss_count}, 4);

        access(0, 32'h40, 0, -1, st, rd);
        check("cf_first_stall", st, 0);
        check("cf_first_rdata", rd, 32'h11);
        access(0, 32'h140, 0, -1, st, rd);
        check("cf_evict_stall", st, 5);
        check("cf_evict_rdata", rd, 32'h1000_0050);
        access(0, 32'h40, 0, -1, st, rd);
        check("cf_back_stall", st, 5);
        check("cf_back_rdata", rd, 32'h11);
        check("cf_counts", {hit_count, miss_count}, {16'd4, 16'd6});

        x0 = xfers;
        access(0, 32'h180, 0, 1, st, rd);
        check("fl_stall", st, 10);
        check("fl_xfers", xfers - x0, 8);
        check("fl_rdata", rd, 32'h1000_0060);
        check("fl_miss_once", {16'b0, miss_count}, 7);
        access(0, 32'h40, 0, -1, st, rd);
        check("fl_cleared", st, 5);
        check("fl_counts", {hit_count, miss_count}, {16'd4, 16'd8});

        @(negedge clk);
        cpu_valid = 1;
        cpu_we = 0;
        cpu_addr = 32'h1C0;
        x0 = xfers;
        repeat (3) @(negedge clk);
        check("mid_xfers", xfers - x0, 2);
        rst = 1;
        cpu_valid = 0;
        #1;
        check("mid_rst_req", {31'b0, mem_req}, 0);
        check("mid_rst_stall", {31'b0, cpu_stall}, 0);
        check("mid_rst_counts", {hit_count, miss_count}, 0);
        @(negedge clk);
        rst = 0;
        x0 = xfers;
        access(0, 32'h1C0, 0, -1, st, rd);
        check("post_rst_stall", st, 5);
        check("post_rst_xfers", xfers - x0, 4);
        check("post_rst_rdata", rd, 32'h1000_0070);
        access(0, 32'h1C4, 0, -1, st, rd);
        check("post_rst_hit", rd, 32'h1000_0071);
        check("post_rst_counts", {hit_count, miss_count}, {16'd1, 16'd1});
        check("final_stable", unstable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
